// File: rtl/dmem_bus_bridge.sv
// Data-memory bus bridge: replays each core load/store as a valid/ready bus request and stalls the core until the response returns.
// Optional response timeout is enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bus_bridge #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_write_data,
  input  logic                  dmem_read,
  input  logic                  dmem_write,
  output logic [DATA_WIDTH-1:0] dmem_read_data,
  output logic                  dmem_ready,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic                  bus_req_we,
  output logic [ADDR_WIDTH-1:0] bus_req_addr,
  output logic [DATA_WIDTH-1:0] bus_req_wdata,
  input  logic                  bus_resp_valid,
  input  logic [DATA_WIDTH-1:0] bus_resp_data,
  input  logic                  bus_resp_err,
  output logic                  err_sticky
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  we_q, we_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    valid_d = valid_q;
    err_d   = err_q;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (dmem_read | dmem_write) begin
          addr_d  = dmem_addr;
          wdata_d = dmem_write_data;
          we_d    = dmem_write;
          valid_d = 1'b1;
          state_d = ST_REQ;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_REQ: begin
        if (bus_req_ready) begin
          valid_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus_resp_valid) begin
          if (!we_q) rdata_d = bus_resp_err ? '0 : bus_resp_data;
          if (bus_resp_err) err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    // The counter reaches TIMEOUT_CYCLES on the edge that abandons the transaction.
    if (state_q == ST_REQ || state_q == ST_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (state_d == state_q && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_DONE;
        valid_d = 1'b0;
        err_d   = 1'b1;
        if (!we_q) rdata_d = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Combinational so the core stalls in the same cycle its request appears.
  always_comb begin
    dmem_ready = 1'b0;
    case (state_q)
      ST_IDLE: dmem_ready = !(dmem_read | dmem_write);
      ST_DONE: dmem_ready = 1'b1;
      default: dmem_ready = 1'b0;
    endcase
  end

  assign dmem_read_data = rdata_q;
  assign bus_req_valid  = valid_q;
  assign bus_req_we     = we_q;
  assign bus_req_addr   = addr_q;
  assign bus_req_wdata  = wdata_q;
  assign err_sticky     = err_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed testbench for dmem_bus_bridge; inputs change and outputs are sampled at the falling edge.
// With DMEM_BRIDGE_TIMEOUT_EN defined it also exercises the response timeout.
module tb_dmem_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_write_data;
  logic        dmem_read;
  logic        dmem_write;
  logic [63:0] dmem_read_data;
  logic        dmem_ready;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_we;
  logic [63:0] bus_req_addr;
  logic [63:0] bus_req_wdata;
  logic        bus_resp_valid;
  logic [63:0] bus_resp_data;
  logic        bus_resp_err;
  logic        err_sticky;

  int vectors = 0;
  int miscompares = 0;

  dmem_bus_bridge #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .dmem_addr(dmem_addr), .dmem_write_data(dmem_write_data),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_read_data(dmem_read_data), .dmem_ready(dmem_ready),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
    .bus_resp_err(bus_resp_err), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge, then let combinational outputs settle.
  task automatic applyStimulus();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    dmem_addr = '0; dmem_write_data = '0; dmem_read = 1'b0; dmem_write = 1'b0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = '0; bus_resp_err = 1'b0;

    repeat (3) applyStimulus();
    checkOutput("rst_valid", 64'(bus_req_valid), 64'd0);
    checkOutput("rst_err", 64'(err_sticky), 64'd0);
    checkOutput("rst_rdata", dmem_read_data, 64'd0);
    checkOutput("rst_ready", 64'(dmem_ready), 64'd1);
    reset = 1'b1;

    // Zero-wait load
    applyStimulus();
    dmem_read = 1'b1; dmem_addr = 64'h1000; bus_req_ready = 1'b1; #1;
    checkOutput("ld_c0_ready", 64'(dmem_ready), 64'd0);
    applyStimulus();
    checkOutput("ld_c1_valid", 64'(bus_req_valid), 64'd1);
    checkOutput("ld_c1_we", 64'(bus_req_we), 64'd0);
    checkOutput("ld_c1_addr", bus_req_addr, 64'h1000);
    checkOutput("ld_c1_ready", 64'(dmem_ready), 64'd0);
    applyStimulus();
    bus_req_ready = 1'b0;
    bus_resp_valid = 1'b1; bus_resp_data = 64'hDEADBEEF_CAFEF00D; #1;
    checkOutput("ld_c2_ready", 64'(dmem_ready), 64'd0);
    checkOutput("ld_c2_valid", 64'(bus_req_valid), 64'd0);
    applyStimulus();
    bus_resp_valid = 1'b0; dmem_read = 1'b0; #1;
    checkOutput("ld_c3_ready", 64'(dmem_ready), 64'd1);
    checkOutput("ld_c3_rdata", dmem_read_data, 64'hDEADBEEF_CAFEF00D);
    applyStimulus();
    checkOutput("ld_c4_idle_ready", 64'(dmem_ready), 64'd1);
    checkOutput("ld_c4_idle_valid", 64'(bus_req_valid), 64'd0);

    // Store with 4 cycles of backpressure
    dmem_write = 1'b1; dmem_addr = 64'h2008; dmem_write_data = 64'h55; #1;
    checkOutput("st_c0_ready", 64'(dmem_ready), 64'd0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus();
      if (i == 5) bus_req_ready = 1'b1;
      checkOutput("st_valid_held", 64'(bus_req_valid), 64'd1);
      checkOutput("st_addr", bus_req_addr, 64'h2008);
      checkOutput("st_wdata", bus_req_wdata, 64'h55);
      checkOutput("st_we", 64'(bus_req_we), 64'd1);
      checkOutput("st_ready_low", 64'(dmem_ready), 64'd0);
    end
    applyStimulus();
    bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 64'h1111; #1;
    checkOutput("st_c6_valid", 64'(bus_req_valid), 64'd0);
    checkOutput("st_c6_ready", 64'(dmem_ready), 64'd0);
    applyStimulus();
    bus_resp_valid = 1'b0; dmem_write = 1'b0; #1;
    checkOutput("st_c7_ready", 64'(dmem_ready), 64'd1);
    checkOutput("st_rdata_kept", dmem_read_data, 64'hDEADBEEF_CAFEF00D);
    applyStimulus();
    checkOutput("st_c8_valid", 64'(bus_req_valid), 64'd0);

    // Load with bus error
    dmem_read = 1'b1; dmem_addr = 64'h3000; bus_req_ready = 1'b1;
    applyStimulus();
    applyStimulus();
    bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_err = 1'b1; bus_resp_data = 64'h1234;
    applyStimulus();
    bus_resp_valid = 1'b0; bus_resp_err = 1'b0; dmem_read = 1'b0; #1;
    checkOutput("err_ready", 64'(dmem_ready), 64'd1);
    checkOutput("err_rdata", dmem_read_data, 64'd0);
    checkOutput("err_sticky", 64'(err_sticky), 64'd1);
    applyStimulus();

    // Good load afterwards; sticky stays set
    dmem_read = 1'b1; dmem_addr = 64'h4000; bus_req_ready = 1'b1;
    applyStimulus();
    applyStimulus();
    bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 64'hABCD;
    applyStimulus();
    bus_resp_valid = 1'b0; dmem_read = 1'b0; #1;
    checkOutput("good_rdata", dmem_read_data, 64'hABCD);
    checkOutput("good_err_sticky", 64'(err_sticky), 64'd1);
    applyStimulus();

    // Read and write both high counts as a write
    dmem_read = 1'b1; dmem_write = 1'b1; dmem_addr = 64'h6000; dmem_write_data = 64'h77;
    applyStimulus();
    bus_req_ready = 1'b1; #1;
    checkOutput("both_we", 64'(bus_req_we), 64'd1);
    checkOutput("both_wdata", bus_req_wdata, 64'h77);
    applyStimulus();
    bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 64'h5A5A;
    applyStimulus();
    bus_resp_valid = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0; #1;
    checkOutput("both_ready", 64'(dmem_ready), 64'd1);
    checkOutput("both_rdata_kept", dmem_read_data, 64'hABCD);
    applyStimulus();

    // Reset in WAIT, then a stray response in IDLE
    dmem_read = 1'b1; dmem_addr = 64'h5000; bus_req_ready = 1'b1;
    applyStimulus();
    applyStimulus();
    bus_req_ready = 1'b0;
    checkOutput("mid_wait_ready", 64'(dmem_ready), 64'd0);
    reset = 1'b0; dmem_read = 1'b0; #1;
    checkOutput("mid_rst_valid", 64'(bus_req_valid), 64'd0);
    checkOutput("mid_rst_err", 64'(err_sticky), 64'd0);
    checkOutput("mid_rst_rdata", dmem_read_data, 64'd0);
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    bus_resp_valid = 1'b1; bus_resp_data = 64'h9999;
    applyStimulus();
    bus_resp_valid = 1'b0;
    applyStimulus();
    checkOutput("stray_rdata", dmem_read_data, 64'd0);
    checkOutput("stray_ready", 64'(dmem_ready), 64'd1);
    checkOutput("stray_valid", 64'(bus_req_valid), 64'd0);
    checkOutput("stray_err", 64'(err_sticky), 64'd0);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    // Load with no response: ready pulses 8 cycles after REQ entry
    dmem_read = 1'b1; dmem_addr = 64'h7000; bus_req_ready = 1'b1;
    applyStimulus();
    bus_req_ready = 1'b0;
    for (int i = 1; i < 8; i++) begin
      checkOutput("to_ready_low", 64'(dmem_ready), 64'd0);
      applyStimulus();
    end
    checkOutput("to_ready_low_last", 64'(dmem_ready), 64'd0);
    applyStimulus();
    dmem_read = 1'b0; #1;
    checkOutput("to_ready", 64'(dmem_ready), 64'd1);
    checkOutput("to_rdata", dmem_read_data, 64'd0);
    checkOutput("to_err", 64'(err_sticky), 64'd1);
    checkOutput("to_valid", 64'(bus_req_valid), 64'd0);
    applyStimulus();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
